// File: rtl/mem_stage_pkg.sv
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Opcode encodings, bus widths, FSM state encoding and
//                per-opcode byte counts shared by the MEM stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    localparam int c_ALUOP_W   = 8;
    localparam int c_REGADDR_W = 5;

    // Opcodes relevant to the MEM stage; every other code is a non-memory op
    localparam logic [c_ALUOP_W-1:0] c_OP_ADD = 8'h20;
    localparam logic [c_ALUOP_W-1:0] c_OP_LB  = 8'hE0;
    localparam logic [c_ALUOP_W-1:0] c_OP_LH  = 8'hE1;
    localparam logic [c_ALUOP_W-1:0] c_OP_LW  = 8'hE3;
    localparam logic [c_ALUOP_W-1:0] c_OP_LBU = 8'hE4;
    localparam logic [c_ALUOP_W-1:0] c_OP_LHU = 8'hE5;
    localparam logic [c_ALUOP_W-1:0] c_OP_SB  = 8'hE8;
    localparam logic [c_ALUOP_W-1:0] c_OP_SH  = 8'hE9;
    localparam logic [c_ALUOP_W-1:0] c_OP_SW  = 8'hEB;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    // Number of bytes moved by an opcode; zero marks a non-memory op
    function automatic logic [2:0] op_bytes(input logic [c_ALUOP_W-1:0] op);
        case (op)
            c_OP_LB, c_OP_LBU, c_OP_SB: op_bytes = 3'd1;
            c_OP_LH, c_OP_LHU, c_OP_SH: op_bytes = 3'd2;
            c_OP_LW, c_OP_SW:           op_bytes = 3'd4;
            default:                    op_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic is_store(input logic [c_ALUOP_W-1:0] op);
        is_store = (op == c_OP_SB) || (op == c_OP_SH) || (op == c_OP_SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_ext.sv
// ============================================================================
//  Module      : mem_load_ext
//  Description : Sign/zero extension of an assembled little-endian load word.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [c_ALUOP_W-1:0] i_aluop,
    input  logic [31:0]          i_word,
    output logic [31:0]          o_result
);

    // Extend the low byte/half according to the load flavour
    always_comb begin
        case (i_aluop)
            c_OP_LB:  o_result = {{24{i_word[7]}}, i_word[7:0]};
            c_OP_LBU: o_result = {24'd0, i_word[7:0]};
            c_OP_LH:  o_result = {{16{i_word[15]}}, i_word[15:0]};
            c_OP_LHU: o_result = {16'd0, i_word[15:0]};
            default:  o_result = i_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline MEM stage. Non-memory results pass straight through;
//                loads/stores are serialised over a byte-wide memory port
//                while the pipeline is stalled.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [c_ALUOP_W-1:0]   aluop_i,
    input  logic [c_REGADDR_W-1:0] wd_i,
    input  logic                   wreg_i,
    input  logic [31:0]            data_i,
    input  logic [31:0]            mem_addr_i,
    input  logic [7:0]             mem_rdata_i,
    input  logic                   mem_ack_i,
    output logic [c_REGADDR_W-1:0] wd_o,
    output logic                   wreg_o,
    output logic [31:0]            wdata_o,
    output logic                   stall_req_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [31:0]            mem_addr_o,
    output logic [7:0]             mem_wdata_o
);

    state_e                   r_state_q, w_state_d;
    logic [c_ALUOP_W-1:0]     r_op_q,    w_op_d;
    logic [c_REGADDR_W-1:0]   r_wd_q,    w_wd_d;
    logic                     r_wreg_q,  w_wreg_d;
    logic [31:0]              r_addr_q,  w_addr_d;
    logic [31:0]              r_sdata_q, w_sdata_d;
    logic [31:0]              r_asm_q,   w_asm_d;
    logic [1:0]               r_k_q,     w_k_d;

    logic                     w_in_is_mem;
    logic                     w_last_byte;
    logic                     w_op_store;
    logic [31:0]              w_load_val;

    assign w_in_is_mem = (op_bytes(aluop_i) != 3'd0);
    assign w_op_store  = is_store(r_op_q);
    assign w_last_byte = ({1'b0, r_k_q} == (op_bytes(r_op_q) - 3'd1));

    mem_load_ext u_load_ext (
        .i_aluop  (r_op_q),
        .i_word   (r_asm_q),
        .o_result (w_load_val)
    );

    // Next-state: latch the op on entry, walk the byte counter on each ack
    always_comb begin
        w_state_d = r_state_q;
        w_op_d    = r_op_q;
        w_wd_d    = r_wd_q;
        w_wreg_d  = r_wreg_q;
        w_addr_d  = r_addr_q;
        w_sdata_d = r_sdata_q;
        w_asm_d   = r_asm_q;
        w_k_d     = r_k_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_in_is_mem) begin
                    w_state_d = S_ACCESS;
                    w_op_d    = aluop_i;
                    w_wd_d    = wd_i;
                    w_wreg_d  = wreg_i;
                    w_addr_d  = mem_addr_i;
                    w_sdata_d = data_i;
                    w_asm_d   = 32'd0;
                    w_k_d     = 2'd0;
                end
            end
            S_ACCESS: begin
                if (mem_ack_i) begin
                    if (!w_op_store) begin
                        w_asm_d[{r_k_q, 3'b000} +: 8] = mem_rdata_i;
                    end
                    if (w_last_byte) begin
                        w_state_d = S_DONE;
                    end else begin
                        w_k_d = r_k_q + 2'd1;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // State and latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_op_q    <= '0;
            r_wd_q    <= '0;
            r_wreg_q  <= 1'b0;
            r_addr_q  <= '0;
            r_sdata_q <= '0;
            r_asm_q   <= '0;
            r_k_q     <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_op_q    <= w_op_d;
            r_wd_q    <= w_wd_d;
            r_wreg_q  <= w_wreg_d;
            r_addr_q  <= w_addr_d;
            r_sdata_q <= w_sdata_d;
            r_asm_q   <= w_asm_d;
            r_k_q     <= w_k_d;
        end
    end

    // Outputs: forced to zero during reset so an aborted access issues nothing
    always_comb begin
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        stall_req_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (!rst) begin
            case (r_state_q)
                S_IDLE: begin
                    if (w_in_is_mem) begin
                        stall_req_o = 1'b1;
                    end else begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = data_i;
                    end
                end
                S_ACCESS: begin
                    stall_req_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = w_op_store;
                    mem_addr_o  = r_addr_q + {30'd0, r_k_q};
                    mem_wdata_o = r_sdata_q[{r_k_q, 3'b000} +: 8];
                end
                S_DONE: begin
                    wd_o = r_wd_q;
                    if (!w_op_store) begin
                        wreg_o  = r_wreg_q;
                        wdata_o = w_load_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Randomised self-checking bench for mem_stage with a byte
//                memory model and arithmetic load/store reference.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] data_i;
    logic [31:0] mem_addr_i;
    logic [7:0]  mem_rdata_i;
    logic        mem_ack_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [bit [31:0]];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .data_i      (data_i),
        .mem_addr_i  (mem_addr_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stall_req_o (stall_req_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input bit [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic int ref_bytes(input logic [7:0] op);
        if (op == c_OP_LB || op == c_OP_LBU || op == c_OP_SB) return 1;
        if (op == c_OP_LH || op == c_OP_LHU || op == c_OP_SH) return 2;
        if (op == c_OP_LW || op == c_OP_SW) return 4;
        return 0;
    endfunction

    function automatic bit ref_store(input logic [7:0] op);
        return (op == c_OP_SB || op == c_OP_SH || op == c_OP_SW);
    endfunction

    // Little-endian value of n bytes, then signed interpretation for Lb/Lh
    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr);
        longint w = 0;
        int n = ref_bytes(op);
        for (int i = 0; i < n; i++) w += longint'(mem_rd(addr + 32'(i))) << (8 * i);
        if (op == c_OP_LB && w >= 128)   w -= 256;
        if (op == c_OP_LH && w >= 32768) w -= 65536;
        return 32'(w);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_wd"},    32'(wd_o), 0);
        check({tag, "_wreg"},  32'(wreg_o), 0);
        check({tag, "_wdata"}, wdata_o, 0);
        check({tag, "_stall"}, 32'(stall_req_o), 0);
        check({tag, "_req"},   32'(mem_req_o), 0);
        check({tag, "_we"},    32'(mem_we_o), 0);
        check({tag, "_addr"},  mem_addr_o, 0);
        check({tag, "_wbyte"}, 32'(mem_wdata_o), 0);
    endtask

    task automatic do_op(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] data, input logic [31:0] addr,
                         input int dmin, input int dmax,
                         input bit use_want, input logic [31:0] want);
        int n;
        bit st;
        int stalls;
        int exp_stalls;
        int d;
        logic [31:0] exp_w;
        logic [31:0] sh;
        n  = ref_bytes(op);
        st = ref_store(op);
        @(negedge clk);
        aluop_i = op; wd_i = wd; wreg_i = wreg; data_i = data; mem_addr_i = addr; mem_ack_i = 1'b0;
        #1;
        if (n == 0) begin
            check("pass_wdata", wdata_o, data);
            check("pass_wd",    32'(wd_o), 32'(wd));
            check("pass_wreg",  32'(wreg_o), 32'(wreg));
            check("pass_stall", 32'(stall_req_o), 0);
            check("pass_req",   32'(mem_req_o), 0);
            return;
        end
        exp_w = st ? 32'd0 : ref_load(op, addr);
        check("idle_stall", 32'(stall_req_o), 1);
        check("idle_req",   32'(mem_req_o), 0);
        stalls = 1;
        exp_stalls = 1;
        for (int i = 0; i < n; i++) begin
            d = $urandom_range(dmax, dmin);
            exp_stalls += d + 1;
            sh = data >> (8 * i);
            for (int j = 0; j <= d; j++) begin
                @(negedge clk);
                mem_ack_i   = (j == d);
                mem_rdata_i = mem_rd(addr + 32'(i));
                #1;
                check("acc_req",  32'(mem_req_o), 1);
                check("acc_addr", mem_addr_o, addr + 32'(i));
                check("acc_we",   32'(mem_we_o), 32'(st));
                if (st) check("acc_wbyte", 32'(mem_wdata_o), 32'(sh[7:0]));
                if (stall_req_o) stalls++;
                if (st && j == d) mem_m[addr + 32'(i)] = sh[7:0];
            end
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
        aluop_i   = c_OP_ADD; wreg_i = 1'b0; data_i = 32'd0; wd_i = 5'd0;
        #1;
        check("done_stall", 32'(stall_req_o), 0);
        check("done_req",   32'(mem_req_o), 0);
        check("done_wreg",  32'(wreg_o), st ? 0 : 32'(wreg));
        check("done_wdata", wdata_o, exp_w);
        if (!st) check("done_wd", 32'(wd_o), 32'(wd));
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        if (use_want) check("directed_val", wdata_o, want);
    endtask

    initial begin
        logic [7:0] ops [8];
        logic [7:0] op;
        logic [31:0] a;
        ops[0] = c_OP_LB; ops[1] = c_OP_LBU; ops[2] = c_OP_LH; ops[3] = c_OP_LHU;
        ops[4] = c_OP_LW; ops[5] = c_OP_SB;  ops[6] = c_OP_SH; ops[7] = c_OP_SW;

        rst = 1'b1; aluop_i = c_OP_ADD; wd_i = 5'd3; wreg_i = 1'b1; data_i = 32'hDEAD_BEEF;
        mem_addr_i = 32'h0; mem_rdata_i = 8'h00; mem_ack_i = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        mem_m[32'h100] = 8'h78; mem_m[32'h101] = 8'h56; mem_m[32'h102] = 8'h34; mem_m[32'h103] = 8'h12;
        mem_m[32'h7]   = 8'h80;
        mem_m[32'h20]  = 8'h00; mem_m[32'h21]  = 8'h90;

        do_op(c_OP_ADD, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 32'h0);
        do_op(c_OP_LW,  5'd9, 1'b1, 32'h0, 32'h100, 0, 0, 1'b1, 32'h1234_5678);
        do_op(c_OP_LB,  5'd1, 1'b1, 32'h0, 32'h7,   0, 0, 1'b1, 32'hFFFF_FF80);
        do_op(c_OP_LBU, 5'd2, 1'b1, 32'h0, 32'h7,   0, 0, 1'b1, 32'h0000_0080);
        do_op(c_OP_LH,  5'd4, 1'b1, 32'h0, 32'h20,  0, 0, 1'b1, 32'hFFFF_9000);
        do_op(c_OP_SH,  5'd6, 1'b1, 32'hAABB_CCDD, 32'hFFFF_FFFF, 3, 3, 1'b0, 32'h0);

        // Reset in the second ACCESS cycle of a word load
        @(negedge clk);
        aluop_i = c_OP_LW; wd_i = 5'd7; wreg_i = 1'b1; mem_addr_i = 32'h300; mem_ack_i = 1'b0;
        @(negedge clk);
        mem_ack_i = 1'b1; mem_rdata_i = 8'h11;
        @(negedge clk);
        rst = 1'b1; mem_ack_i = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0; aluop_i = c_OP_ADD; wreg_i = 1'b0; wd_i = 5'd0; data_i = 32'h0;
        #1;
        check("post_rst_stall", 32'(stall_req_o), 0);
        check("post_rst_req",   32'(mem_req_o), 0);
        check("post_rst_wreg",  32'(wreg_o), 0);

        // Spurious ack while idle with a non-memory op
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            aluop_i = c_OP_ADD; wd_i = 5'(i + 10); wreg_i = 1'b1; data_i = 32'hC0DE_0000 + 32'(i);
            mem_ack_i = 1'b1;
            #1;
            check("spur_stall", 32'(stall_req_o), 0);
            check("spur_req",   32'(mem_req_o), 0);
            check("spur_wdata", wdata_o, 32'hC0DE_0000 + 32'(i));
        end
        @(negedge clk);
        mem_ack_i = 1'b0;

        // Randomised mix of memory and non-memory ops
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(3, 0) == 0) begin
                op = 8'($urandom_range(255, 0));
                while (ref_bytes(op) != 0) op = 8'($urandom_range(255, 0));
            end else begin
                op = ops[$urandom_range(7, 0)];
            end
            if ($urandom_range(3, 0) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(3, 0));
            else a = 32'($urandom_range(255, 0));
            do_op(op, 5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)), $urandom, a,
                  0, 2, 1'b0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage of the RISC-V core, directly downstream of the EX stage. It consumes EX results (opcode, destination, data, effective address) and performs loads/stores over a byte-wide memory port, one byte per handshake. It assembles or sign/zero-extends load data and passes non-memory results through to writeback. It stalls the pipeline for the whole duration of a memory access.

## Interface
- Parameters: none. Opcode encodings and bus widths come from `defines.v`.
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high (`RstEnable`)
- aluop_i  in  `AluOpBus`  opcode from EX
- wd_i  in  `RegAddrBus`  destination register
- wreg_i  in  1  register write enable from EX
- data_i  in  32  ALU result (non-memory ops) or store data (Sb/Sh/Sw)
- mem_addr_i  in  32  effective address (loads/stores)
- mem_rdata_i  in  8  byte read from memory
- mem_ack_i  in  1  memory completed current byte transfer
- wd_o  out  `RegAddrBus`  destination to writeback
- wreg_o  out  1  write enable to writeback
- wdata_o  out  32  result to writeback
- stall_req_o  out  1  pipeline stall request; upstream holds all inputs stable while high
- mem_req_o  out  1  byte transfer request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  byte address
- mem_wdata_o  out  8  byte to write

## Operation
- Memory ops: Lb, Lbu, Sb (1 byte); Lh, Lhu, Sh (2 bytes); Lw, Sw (4 bytes). All other opcodes are non-memory.
- FSM states: IDLE, ACCESS, DONE.
- IDLE with a non-memory op: outputs pass through combinationally (wd_o=wd_i, wreg_o=wreg_i, wdata_o=data_i), stall_req_o=0, and the state stays IDLE.
- IDLE with a memory op: stall_req_o=1. Next edge: latch op, address, store data; byte counter k=0; go to ACCESS.
- ACCESS: mem_req_o=1, mem_addr_o=base+k (mod 2^32), mem_we_o=1 for stores. mem_wdata_o = store data bits [8k+7:8k]. stall_req_o=1.
  - On an edge with mem_ack_i=1, a load captures mem_rdata_i into byte k of the assembly register.
  - If k is the last byte, go to DONE; otherwise k increments and ACCESS continues.
- DONE: stall_req_o=0 and mem_req_o=0. Next edge returns to IDLE.
  - Loads: wreg_o=latched wreg, wd_o=latched wd. wdata_o is the assembled value: Lb/Lh sign-extend from bit 7/15, Lbu/Lhu zero-extend, Lw is taken whole.
  - Stores: wreg_o=0, wdata_o=0.
- Little-endian byte order. Misaligned addresses are legal; they are handled bytewise.
- mem_ack_i is ignored outside ACCESS.

## Timing
- Reset (rst=1 at an edge): state IDLE, k=0, all latches 0. While rst is high, all outputs are 0: wd_o, wreg_o, wdata_o, stall_req_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o.
- Reset during ACCESS aborts the transfer. mem_req_o is 0 from the reset cycle onward, and no writeback occurs.
- Non-memory op: 0 cycles of added latency, no stall.
- Memory op with N bytes and an ack in the same cycle as each request: stall_req_o is high for N+1 cycles (IDLE cycle plus N ACCESS cycles). The result is valid in the DONE cycle.
- When ack is delayed, mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o hold stable until the ack edge.
- Back-to-back memory ops: after DONE the state returns to IDLE. The next op's request starts at the earliest 2 cycles after DONE.

## Structure
- State encodings (2-bit) and the byte-count constant per op go in `defines.v`, next to the existing opcode definitions.
- One natural sub-module: `mem_load_ext`. It is combinational: it takes the opcode and the 32-bit assembled word and produces the sign/zero-extended result.
- The FSM, byte counter and latches live in mem_stage.

## Test plan
- Pass-through: Add op, data_i=0x1234_5678, wd_i=5, wreg_i=1 -> same cycle: wdata_o=0x1234_5678, wd_o=5, wreg_o=1, stall_req_o=0, mem_req_o=0.
- Lw at 0x100 (bytes 78,56,34,12), ack in the same cycle each time -> mem_addr_o is 0x100..0x103 over 4 ACCESS cycles; stall_req_o is high for 5 cycles; DONE gives wdata_o=0x1234_5678.
- Lb at 0x7 with byte 0x80 -> wdata_o=0xFFFF_FF80. The same with Lbu -> 0x0000_0080. Lh on bytes 0x00,0x90 -> 0xFFFF_9000.
- Sh at 0xFFFF_FFFF, data_i=0xAABB_CCDD, ack delayed 3 cycles per byte -> writes 0xDD to 0xFFFF_FFFF, then 0xCC to 0x0000_0000 (wrap). Request signals stay stable while waiting. DONE has wreg_o=0.
- rst asserted in the 2nd ACCESS cycle of Lw -> next cycle: all outputs 0, state IDLE. No writeback.
- Spurious mem_ack_i=1 during IDLE with a non-memory op -> no state change, no stall.
